// File: rtl/mac_gemm_engine.sv
// mac_gemm_engine: M x K by K x N integer matrix multiply-accumulate engine.
// A valid/ready load captures A, B and the mode bits. LANES MAC lanes then
// walk the (i, jg, k) iteration space through a two-stage pipeline (product
// register, then accumulate into a per-lane partial sum). After a two-cycle
// drain, C is presented with valid/ready. C is retained between operations
// so that a later load with acc_mode=1 adds into it.
module mac_gemm_engine #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(K),
  parameter int LANES      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host2block_val,
  output logic                          host2block_rdy,
  input  logic [M*K*DATA_WIDTH-1:0]     a_data_in,
  input  logic [N*K*DATA_WIDTH-1:0]     b_data_in,
  input  logic                          signed_mode,
  input  logic                          acc_mode,
  output logic                          block2host_val,
  input  logic                          block2host_rdy,
  output logic [M*N*ACC_WIDTH-1:0]      c_data_out,
  output logic                          mac_done
);

  localparam int JG  = N / LANES;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int KW  = (K  > 1) ? $clog2(K)  : 1;
  localparam int JW  = (JG > 1) ? $clog2(JG) : 1;
  localparam int IW  = (M  > 1) ? $clog2(M)  : 1;
  localparam int AIW = (M*K > 1) ? $clog2(M*K) : 1;
  localparam int BIW = (N*K > 1) ? $clog2(N*K) : 1;
  localparam int CIW = (M*N > 1) ? $clog2(M*N) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q [M*K];
  logic [DATA_WIDTH-1:0] b_q [N*K];
  logic                  signed_q, acc_q;
  logic [KW-1:0]         k_q;
  logic [JW-1:0]         jg_q;
  logic [IW-1:0]         i_q;
  logic                  drain_q;
  logic                  s1_val_q;
  logic [KW-1:0]         s1_k_q;
  logic [JW-1:0]         s1_jg_q;
  logic [IW-1:0]         s1_i_q;
  logic [ACC_WIDTH-1:0]  prod_q   [LANES];
  logic [ACC_WIDTH-1:0]  psum_q   [LANES];
  logic [ACC_WIDTH-1:0]  c_q      [M*N];
  logic                  mac_done_q;

  logic                  load;
  logic                  last_k, last_jg, last_i, last_issue;
  logic [ACC_WIDTH-1:0]  issue_prod [LANES];
  logic [ACC_WIDTH-1:0]  lane_sum   [LANES];
  logic [CIW-1:0]        lane_cidx  [LANES];

  assign host2block_rdy = (state_q == IDLE) && !rst;
  assign load           = host2block_val && host2block_rdy;
  assign block2host_val = (state_q == DONE);
  assign mac_done       = mac_done_q;

  assign last_k     = (k_q  == KW'(K - 1));
  assign last_jg    = (jg_q == JW'(JG - 1));
  assign last_i     = (i_q  == IW'(M - 1));
  assign last_issue = (state_q == COMPUTE) && last_k && last_jg && last_i;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch
    // is inferred when a case arm leaves the signal untouched.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load)           state_d = COMPUTE;
      COMPUTE: if (last_issue)     state_d = DRAIN;
      DRAIN:   if (drain_q)        state_d = DONE;
      DONE:    if (block2host_rdy) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Operand and mode capture on the load handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < M*K; x++) a_q[x] <= '0;
      for (int x = 0; x < N*K; x++) b_q[x] <= '0;
      signed_q <= 1'b0;
      acc_q    <= 1'b0;
    end else if (load) begin
      for (int x = 0; x < M*K; x++) a_q[x] <= a_data_in[x*DATA_WIDTH +: DATA_WIDTH];
      for (int x = 0; x < N*K; x++) b_q[x] <= b_data_in[x*DATA_WIDTH +: DATA_WIDTH];
      signed_q <= signed_mode;
      acc_q    <= acc_mode;
    end
  end

  // Issue counters: k innermost, then lane group, then row.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      k_q  <= '0;
      jg_q <= '0;
      i_q  <= '0;
    end else if (state_q == COMPUTE) begin
      k_q <= last_k ? '0 : k_q + KW'(1);
      if (last_k)            jg_q <= last_jg ? '0 : jg_q + JW'(1);
      if (last_k && last_jg) i_q  <= last_i  ? '0 : i_q + IW'(1);
    end
  end

  // Drain counter toggles through the two flush cycles; mac_done marks the
  // DRAIN->DONE transition so it cannot re-fire while DONE is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_q    <= 1'b0;
      mac_done_q <= 1'b0;
    end else begin
      drain_q    <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      mac_done_q <= (state_q == DRAIN) && drain_q;
    end
  end

  // Per-lane operand extension and product for the current issue slot.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [AIW-1:0]        a_idx;
      logic [BIW-1:0]        b_idx;
      logic [PW-1:0]         a_ext, b_ext, p;
      a_idx = AIW'(int'(i_q) * K + int'(k_q));
      b_idx = BIW'((int'(jg_q) * LANES + l) * K + int'(k_q));
      a_ext = signed_q ? PW'($signed(a_q[a_idx])) : PW'(a_q[a_idx]);
      b_ext = signed_q ? PW'($signed(b_q[b_idx])) : PW'(b_q[b_idx]);
      p     = a_ext * b_ext;
      issue_prod[l] = signed_q ? ACC_WIDTH'($signed(p)) : ACC_WIDTH'(p);
    end
  end

  // Stage-2 sum: seed from retained C (or zero) on k=0, else the partial sum.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [ACC_WIDTH-1:0] seed;
      lane_cidx[l] = CIW'(int'(s1_i_q) * N + int'(s1_jg_q) * LANES + l);
      seed         = acc_q ? c_q[lane_cidx[l]] : '0;
      lane_sum[l]  = ((s1_k_q == '0) ? seed : psum_q[l]) + prod_q[l];
    end
  end

  // Stage 1 (products and their coordinates) and stage-2 partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val_q <= 1'b0;
      s1_k_q   <= '0;
      s1_jg_q  <= '0;
      s1_i_q   <= '0;
      for (int l = 0; l < LANES; l++) begin
        prod_q[l] <= '0;
        psum_q[l] <= '0;
      end
    end else begin
      s1_val_q <= (state_q == COMPUTE);
      s1_k_q   <= k_q;
      s1_jg_q  <= jg_q;
      s1_i_q   <= i_q;
      for (int l = 0; l < LANES; l++) begin
        prod_q[l] <= issue_prod[l];
        if (s1_val_q) psum_q[l] <= lane_sum[l];
      end
    end
  end

  // Result matrix: cleared by reset or an overwrite load, written at k=K-1.
  always_ff @(posedge clk) begin
    // NOTE: C is visible state that an abort must clear, so this storage is
    // reset explicitly rather than left as reset-less RAM.
    if (rst || (load && !acc_mode)) begin
      for (int x = 0; x < M*N; x++) c_q[x] <= '0;
    end else if (s1_val_q && (s1_k_q == KW'(K - 1))) begin
      for (int l = 0; l < LANES; l++) c_q[lane_cidx[l]] <= lane_sum[l];
    end
  end

  // Flatten C onto the output bus.
  always_comb begin
    c_data_out = '0;
    for (int x = 0; x < M*N; x++) c_data_out[x*ACC_WIDTH +: ACC_WIDTH] = c_q[x];
  end

endmodule

// File: doc/mac_gemm_engine.md
# mac_gemm_engine

Parametrised matrix multiply-accumulate engine: computes C = A·B, or C += A·B, for M×K by K×N integer matrices with selectable signed/unsigned arithmetic and LANES parallel MAC lanes. Next-generation replacement for the fixed 4×4×4 unsigned MAC top. It uses the same host-side valid/ready load handshake and block-side valid/ready result handshake. Sits between the host interface and the result buffer.

## Interface
- M, 4, rows of A and C
- K, 4, inner dimension
- N, 4, columns of B and C
- DATA_WIDTH, 8, operand width
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K), result element width
- LANES, 1, parallel MAC lanes; must divide N
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- host2block_val  in  1  host offers operands
- host2block_rdy  out  1  engine can accept operands
- a_data_in  in  M*K*DATA_WIDTH  A, element (i,k) at index i*K+k
- b_data_in  in  N*K*DATA_WIDTH  B transposed, element (j,k) at index j*K+k
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
- acc_mode  in  1  1 = add into retained C, 0 = overwrite C
- block2host_val  out  1  C valid
- block2host_rdy  in  1  host accepts C
- c_data_out  out  M*N*ACC_WIDTH  C, element (i,j) at index i*N+j
- mac_done  out  1  one-cycle pulse when C first becomes valid

## Operation
- States: IDLE, COMPUTE, DRAIN, DONE.
- IDLE: host2block_rdy=1. On host2block_val&host2block_rdy:
  - capture A, B, signed_mode and acc_mode into internal registers;
  - clear C if acc_mode=0; leave C unchanged if acc_mode=1;
  - go to COMPUTE.
- COMPUTE: counters k (0..K-1, innermost), jg (0..N/LANES-1), i (0..M-1, outermost).
  - Each cycle, lane l multiplies a(i,k) by b(jg*LANES+l,k).
  - Operands are sign-extended when signed_mode=1, zero-extended otherwise.
  - After the last issue (i=M-1, jg max, k=K-1), go to DRAIN.
- Pipeline: stage 1 registers the products (2*DATA_WIDTH, extended to ACC_WIDTH). Stage 2 adds each product into the lane partial sum.
  - On k=0 the partial sum is seeded from C(i,j) when acc_mode=1, else from 0.
  - When k=K-1 reaches stage 2, the result is written to C(i,j).
- DRAIN: 2 cycles to flush the pipeline, then DONE.
- DONE: block2host_val=1 and C is stable. mac_done pulses on the first DONE cycle only. On block2host_val&block2host_rdy, go to IDLE.
- C is retained after DONE, so a later load with acc_mode=1 adds into it.
- Arithmetic wraps modulo 2^ACC_WIDTH (two's complement); there is no saturation.
- host2block_val outside IDLE is ignored; operand inputs are don't-care outside the load cycle.

## Timing
- Reset values: state IDLE, host2block_rdy=0 during the rst cycle then 1, block2host_val=0, mac_done=0, c_data_out=0, all counters and pipeline registers 0.
- Load handshake in cycle t: first COMPUTE cycle is t+1.
- Compute length: P = M*(N/LANES)*K issue cycles.
- block2host_val first high in cycle t+1+P+2 (after 2 DRAIN cycles); mac_done high in that cycle only.
- Defaults: LANES=1 gives t+67; LANES=4 gives t+19.
- DONE lasts at least 1 cycle. On handshake in cycle d, IDLE holds with host2block_rdy=1 in d+1; back-to-back loads are allowed from d+1.
- Backpressure: while block2host_rdy=0, block2host_val and c_data_out hold indefinitely, and mac_done does not re-pulse.
- rst asserted in any state (mid-COMPUTE, DRAIN, DONE) aborts the operation: next cycle is IDLE and C is cleared.
- rst takes priority over any simultaneous handshake.

## Test plan
- Defaults, LANES=1, A(i,k)=i*4+k, B(k,j)=k*4+j (driven transposed), signed_mode=0, acc_mode=0 -> block2host_val at t+67; C(0,0)=56, C(0,1)=62, C(3,3)=506; mac_done one cycle.
- Same data with LANES=4 -> identical C, block2host_val at t+19.
- Repeat case 1 immediately with acc_mode=1 -> C(0,0)=112, C(3,3)=1012.
- All A=0xFF, all B=0x02:
  - signed_mode=1 -> every C=0x3FFF8 (−8 in 18 bits);
  - signed_mode=0 -> every C=2040.
- Hold block2host_rdy=0 for 10 cycles in DONE -> val and C stable, host2block_rdy=0, exactly one mac_done pulse; raise rdy -> IDLE next cycle.
- Assert rst for 1 cycle mid-COMPUTE (cycle t+20) -> next cycle IDLE, all outputs 0, C=0; a subsequent acc_mode=1 run of case 1 gives the case-1 values.
